// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM states, bus-mux select codes and default pointer step for dma_bus_ctrl
package dma_pkg;
  localparam int ADDR_STEP_DEF = 4;
  typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE, GAP} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_CPU, SEL_RD, SEL_WR} sel_t;
endpackage

// File: rtl/bus_mux_mem.sv
// bus_mux_mem: steers either the core or the DMA read/write phase onto the RAM port
module bus_mux_mem import dma_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  sel_t              sel,
  input  logic              cpu_mem_rd,
  input  logic              cpu_mem_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [ADDR_W-1:0] src_ptr,
  input  logic [ADDR_W-1:0] dst_ptr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr
);
  // a stalled core is cut off entirely; the DMA write forwards last cycle's read data
  always_comb begin
    mem_addr  = sel == SEL_CPU ? cpu_addr : sel == SEL_RD ? src_ptr : sel == SEL_WR ? dst_ptr : '0;
    mem_wdata = sel == SEL_CPU ? cpu_wdata : sel == SEL_WR ? mem_rdata : '0;
    mem_rd    = sel == SEL_CPU ? cpu_mem_rd : sel == SEL_RD;
    mem_wr    = sel == SEL_CPU ? cpu_mem_wr : sel == SEL_WR;
  end
endmodule

// File: rtl/dma_bus_ctrl.sv
// dma_bus_ctrl: core memory-bus owner with stall-handshaked block copy; DMA_CYCLE_STEAL_EN returns the bus to the core for one GAP cycle between words
module dma_bus_ctrl import dma_pkg::*; #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_rd,
  input  logic              cpu_mem_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              Check_out,
  input  logic              Check_in,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state;
  sel_t              sel;
  logic              pass_q;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0]  count;
  bus_mux_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .sel(sel), .cpu_mem_rd(cpu_mem_rd), .cpu_mem_wr(cpu_mem_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .src_ptr(src_ptr), .dst_ptr(dst_ptr), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr)
  );
  // transfer FSM; the mux select is registered alongside the state so it always names the current phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= SEL_NONE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      count     <= '0;
      Check_out <= 1'b0;
      dma_busy  <= 1'b0;
      dma_done  <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: if (dma_start && dma_len != '0) begin
                state     <= REQ;
                sel       <= SEL_NONE;
                src_ptr   <= dma_src;
                dst_ptr   <= dma_dst;
                count     <= dma_len;
                Check_out <= 1'b1;
                dma_busy  <= 1'b1;
              end else if (dma_start) begin
                state    <= DONE;
                sel      <= SEL_NONE;
                dma_done <= 1'b1;
              end else sel <= SEL_CPU;
        REQ:  if (Check_in) begin
                state <= RD;
                sel   <= SEL_RD;
              end
        RD:   begin
                state <= WR;
                sel   <= SEL_WR;
              end
        WR:   begin
                src_ptr <= src_ptr + ADDR_W'(ADDR_STEP);
                dst_ptr <= dst_ptr + ADDR_W'(ADDR_STEP);
                count   <= count - LEN_W'(1);
                if (count == LEN_W'(1)) begin
                  state     <= DONE;
                  sel       <= SEL_NONE;
                  Check_out <= 1'b0;
                  dma_busy  <= 1'b0;
                  dma_done  <= 1'b1;
                end else begin
`ifdef DMA_CYCLE_STEAL_EN
                  state     <= GAP;
                  sel       <= SEL_CPU;
                  Check_out <= 1'b0;
`else
                  state <= RD;
                  sel   <= SEL_RD;
`endif
                end
              end
        GAP:  begin
                state     <= REQ;
                sel       <= SEL_NONE;
                Check_out <= 1'b1;
              end
        DONE: begin
                state <= IDLE;
                sel   <= SEL_CPU;
              end
        default: begin
                state <= IDLE;
                sel   <= SEL_CPU;
              end
      endcase
    end
  // read data reaches the core only for accesses the core itself issued on the previous cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pass_q    <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      pass_q <= sel == SEL_CPU;
      if (pass_q) cpu_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_dma_bus_ctrl.sv
// tb_dma_bus_ctrl: table, hand-written and randomized checks of dma_bus_ctrl against a word-copy memory model
module tb_dma_bus_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_mem_rd, cpu_mem_wr, Check_in, dma_start;
  logic [31:0] cpu_addr, cpu_wdata, dma_src, dma_dst, mem_rdata;
  logic [7:0]  dma_len;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        Check_out, dma_busy, dma_done, mem_rd, mem_wr;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] ram [logic [31:0]];

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    logic [7:0]  n;
    int          dly;
    int          cyc;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  dma_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_mem_rd(cpu_mem_rd), .cpu_mem_wr(cpu_mem_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .Check_out(Check_out), .Check_in(Check_in), .dma_start(dma_start),
    .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len), .dma_busy(dma_busy),
    .dma_done(dma_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= rd(mem_addr);
    if (mem_wr) ram[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int steal_extra(input int n);
`ifdef DMA_CYCLE_STEAL_EN
    return n > 1 ? 2 * (n - 1) : 0;
`else
    return 0 * n;
`endif
  endfunction

  function automatic int exp_cycles(input int n, input int dly);
    return n == 0 ? 1 : 2 + dly + 2 * n + steal_extra(n);
  endfunction

  task automatic dma(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                     input int dly, input int ecyc, input bit spoil);
    logic [31:0] exp[$];
    logic [31:0] rq[$];
    logic [31:0] wq[$];
    int cyc;
    bit done, co, early;
    for (int i = 0; i < int'(n); i++) ram[s + 32'(4 * i)] = $urandom;
    for (int i = 0; i < int'(n); i++) exp.push_back(rd(s + 32'(4 * i)));
    @(negedge clk);
    dma_start = 1'b1; dma_src = s; dma_dst = d; dma_len = n; Check_in = 1'b0;
    cyc = 0; done = 1'b0; co = 1'b0; early = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      dma_start = spoil && cyc == 3;
      if (spoil && cyc == 3) begin
        dma_dst = 32'hF000;
        dma_len = 8'd1;
      end
      if (Check_out) co = 1'b1;
      if (mem_rd) rq.push_back(mem_addr);
      if (mem_wr) wq.push_back(mem_addr);
      if (mem_rd && cyc <= dly) early = 1'b1;
      if (dma_done) done = 1'b1;
      Check_in = cyc > dly;
    end
    dma_start = 1'b0;
    Check_in = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("done_cycle", 32'(cyc), 32'(ecyc));
    chk("busy_at_done", 32'(dma_busy), 32'd0);
    chk("stall_seen", 32'(co), 32'(n != 0));
    chk("read_during_wait", 32'(early), 32'd0);
    chk("read_count", 32'(rq.size()), 32'(n));
    chk("write_count", 32'(wq.size()), 32'(n));
    for (int i = 0; i < rq.size() && i < int'(n); i++) chk("read_addr", rq[i], s + 32'(4 * i));
    for (int i = 0; i < wq.size() && i < int'(n); i++) chk("write_addr", wq[i], d + 32'(4 * i));
    for (int i = 0; i < int'(n); i++) chk("copy_data", rd(d + 32'(4 * i)), exp[i]);
    if (spoil) chk("ignored_start_dst", rd(32'hF000), 32'h0);
    @(negedge clk);
    chk("done_one_cycle", 32'(dma_done), 32'd0);
    chk("stall_released", 32'(Check_out), 32'd0);
  endtask

  initial begin
    cpu_mem_rd = 1'b1; cpu_mem_wr = 1'b1; cpu_addr = 32'h55; cpu_wdata = 32'h77;
    Check_in = 1'b0; dma_start = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
    mem_rdata = '0;
    tbl[0] = '{32'h100, 32'h200, 8'd4, 0, 10};
    tbl[1] = '{32'h300, 32'h400, 8'd4, 5, 15};
    tbl[2] = '{32'h500, 32'h600, 8'd1, 0, 4};
    tbl[3] = '{32'h700, 32'h800, 8'd0, 0, 1};
    tbl[4] = '{32'hFFFFFFFC, 32'h900, 8'd2, 0, 6};
    tbl[5] = '{32'hA00, 32'hB00, 8'd3, 2, 10};
    repeat (2) @(negedge clk);
    chk("rst_check_out", 32'(Check_out), 32'd0);
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_done", 32'(dma_done), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    cpu_mem_rd = 1'b0; cpu_mem_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cpu_mem_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("cpu_write_ram", rd(32'h10), 32'hDEADBEEF);
    cpu_mem_wr = 1'b0; cpu_mem_rd = 1'b1;
    @(negedge clk);
    cpu_mem_rd = 1'b0;
    @(negedge clk);
    chk("cpu_read_data", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_no_stall", 32'(Check_out), 32'd0);
    for (int i = 0; i < 6; i++)
      dma(tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].dly, tbl[i].cyc + steal_extra(int'(tbl[i].n)), 1'b0);
    dma(32'h2000, 32'h3000, 8'd4, 0, exp_cycles(4, 0), 1'b1);
    @(negedge clk);
    dma_start = 1'b1; dma_src = 32'h2100; dma_dst = 32'h3100; dma_len = 8'd3; Check_in = 1'b0;
    @(negedge clk);
    dma_start = 1'b0;
    @(negedge clk);
    chk("req_stall", 32'(Check_out), 32'd1);
    chk("req_busy", 32'(dma_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_check_out", 32'(Check_out), 32'd0);
    chk("async_rst_busy", 32'(dma_busy), 32'd0);
    chk("async_rst_mem_rd", 32'(mem_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      int n, dly;
      n = int'($urandom_range(0, 6));
      dly = int'($urandom_range(0, 3));
      dma(32'h1000 + 32'(4 * $urandom_range(0, 255)), 32'h8000 + 32'(4 * $urandom_range(0, 255)),
          8'(n), dly, exp_cycles(n, dly), 1'b0);
    end
`ifdef DMA_CYCLE_STEAL_EN
    begin
      int cyc;
      ram[32'h4000] = 32'h11; ram[32'h4004] = 32'h22;
      @(negedge clk);
      dma_start = 1'b1; dma_src = 32'h4000; dma_dst = 32'h5000; dma_len = 8'd2; Check_in = 1'b1;
      @(negedge clk);
      dma_start = 1'b0;
      cyc = 0;
      while (!(dma_busy && !Check_out) && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk("gap_reached", 32'(dma_busy && !Check_out), 32'd1);
      cpu_mem_wr = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'hCAFEF00D;
      @(negedge clk);
      cpu_mem_wr = 1'b0;
      cyc = 0;
      while (!dma_done && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk("gap_done_seen", 32'(dma_done), 32'd1);
      chk("gap_core_write", rd(32'h60), 32'hCAFEF00D);
      chk("gap_copy_word1", rd(32'h5004), 32'h22);
      Check_in = 1'b0;
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
